// File: rtl/mdr_pkg.sv
// Shared types for the MDR datapath and its result sender.
package mdr_pkg;

    // Operation encoding used by the MDR core; 2'b11 is unassigned.
    typedef enum logic [1:0] {
        MUL  = 2'b00,
        DIV  = 2'b01,
        SQRT = 2'b10
    } op_t;

    // Beat type presented to the downstream consumer.
    typedef enum logic [1:0] {
        RES = 2'b00,
        REM = 2'b01,
        ERR = 2'b10
    } tag_t;

    // Result sender sequencing.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SEND_RES = 2'b01,
        SEND_REM = 2'b10
    } sender_state_t;

endpackage

// File: rtl/mdr_hold_reg.sv
// Enabled hold register with synchronous active-high reset to zero.
module mdr_hold_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_reg;

    // Load on enable, clear on reset, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mdr_result_sender.sv
// Captures a finished MDR result on done and delivers it as one or two
// beats over a valid/ready handshake, with zero-bubble back-to-back capture.
module mdr_result_sender
    import mdr_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done,
    input  logic [1:0]    op,
    input  logic          error,
    input  logic [DW-1:0] result,
    input  logic [DW-1:0] remainder,
    input  logic          tx_ready,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    output logic [1:0]    tx_tag,
    output logic          tx_last,
    output logic          busy,
    output logic          overrun
);

    sender_state_t state_reg;
    sender_state_t state_next;
    logic          overrun_reg;
    logic          overrun_next;

    logic [DW-1:0] hold_result;
    logic [DW-1:0] hold_remainder;
    logic [1:0]    hold_op;
    logic [0:0]    hold_error;

    logic          capture;
    logic          handshake;
    logic [DW-1:0] beat_data;
    tag_t          beat_tag;
    logic          beat_last;
    logic          beat_valid;

    // One hold register per captured field, all loaded together on capture.
    mdr_hold_reg #(.DW(DW)) u_hold_result (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .d   (result),
        .q   (hold_result)
    );

    mdr_hold_reg #(.DW(DW)) u_hold_remainder (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .d   (remainder),
        .q   (hold_remainder)
    );

    mdr_hold_reg #(.DW(2)) u_hold_op (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .d   (op),
        .q   (hold_op)
    );

    mdr_hold_reg #(.DW(1)) u_hold_error (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .d   (error),
        .q   (hold_error)
    );

    // Beat decode from state and held fields only, so nothing here depends
    // on tx_ready or done and the beat stays stable during a stall.
    always_comb begin
        beat_data  = '0;
        beat_tag   = RES;
        beat_last  = 1'b0;
        beat_valid = 1'b0;
        case (state_reg)
            SEND_RES: begin
                beat_valid = 1'b1;
                if (hold_error[0] || (hold_op == 2'b11)) begin
                    beat_data = '0;
                    beat_tag  = ERR;
                    beat_last = 1'b1;
                end else if (hold_op == 2'(MUL)) begin
                    beat_data = hold_result;
                    beat_tag  = RES;
                    beat_last = 1'b1;
                end else begin
                    beat_data = hold_result;
                    beat_tag  = RES;
                    beat_last = 1'b0;
                end
            end
            SEND_REM: begin
                beat_valid = 1'b1;
                beat_data  = hold_remainder;
                beat_tag   = REM;
                beat_last  = 1'b1;
            end
            default: begin
                beat_valid = 1'b0;
            end
        endcase
    end

    // Capture when idle, or when the final beat leaves in the same cycle;
    // any other done is dropped and flagged as overrun.
    always_comb begin
        handshake    = beat_valid && tx_ready;
        capture      = done && ((state_reg == IDLE) || (handshake && beat_last));
        overrun_next = overrun_reg || (done && !capture);
        state_next   = state_reg;
        if (capture) begin
            state_next = SEND_RES;
        end else if (handshake) begin
            state_next = beat_last ? IDLE : SEND_REM;
        end
    end

    // State and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            overrun_reg <= overrun_next;
        end
    end

    assign tx_valid = beat_valid;
    assign busy     = beat_valid;
    assign tx_data  = beat_data;
    assign tx_tag   = beat_tag;
    assign tx_last  = beat_last;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_mdr_result_sender.sv
// Directed self-checking bench for mdr_result_sender (DW = 4).
module tb_mdr_result_sender;

    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          done;
    logic [1:0]    op;
    logic          error;
    logic [DW-1:0] result;
    logic [DW-1:0] remainder;
    logic          tx_ready;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic [1:0]    tx_tag;
    logic          tx_last;
    logic          busy;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    mdr_result_sender #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .op        (op),
        .error     (error),
        .result    (result),
        .remainder (remainder),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_tag    (tx_tag),
        .tx_last   (tx_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per transferred beat.
    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready)
            $display("beat: data=%h tag=%0d last=%0b", tx_data, tx_tag, tx_last);
    end

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a done pulse with the given fields for the next edge.
    task automatic pulse_done(input logic [1:0] o, input logic e,
                              input logic [3:0] r, input logic [3:0] m);
        done = 1'b1; op = o; error = e; result = r; remainder = m;
        step();
        done = 1'b0; error = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({tx_valid, busy, tx_last, overrun} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got v/b/l/o=%b want 0000", {tx_valid, busy, tx_last, overrun});
        end
        total++;
        if ({tx_data, tx_tag} !== 6'b0) begin
            bad++;
            $display("FAIL reset_beat: got data=%h tag=%0d want 0/0", tx_data, tx_tag);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_mul();
        tx_ready = 1'b1;
        pulse_done(2'b00, 1'b0, 4'hC, 4'h0);
        total++;
        if ({tx_valid, busy, tx_data, tx_tag, tx_last} !== {1'b1, 1'b1, 4'hC, 2'b00, 1'b1}) begin
            bad++;
            $display("FAIL mul_beat: got v=%b b=%b d=%h t=%0d l=%b want 1 1 C 0 1",
                     tx_valid, busy, tx_data, tx_tag, tx_last);
        end
        step();
        total++;
        if ({tx_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL mul_idle: got v=%b b=%b want 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_div_stall();
        tx_ready = 1'b0;
        pulse_done(2'b01, 1'b0, 4'h3, 4'h2);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({tx_valid, tx_data, tx_tag, tx_last} !== {1'b1, 4'h3, 2'b00, 1'b0}) begin
                bad++;
                $display("FAIL div_stall_%0d: got v=%b d=%h t=%0d l=%b want 1 3 0 0",
                         i, tx_valid, tx_data, tx_tag, tx_last);
            end
            step();
        end
        tx_ready = 1'b1;
        step();
        total++;
        if ({tx_valid, tx_data, tx_tag, tx_last} !== {1'b1, 4'h2, 2'b01, 1'b1}) begin
            bad++;
            $display("FAIL div_rem: got v=%b d=%h t=%0d l=%b want 1 2 1 1",
                     tx_valid, tx_data, tx_tag, tx_last);
        end
        step();
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL div_idle: got v=%b want 0", tx_valid);
        end
    endtask

    task automatic test_error();
        tx_ready = 1'b1;
        pulse_done(2'b01, 1'b1, 4'h7, 4'h5);
        total++;
        if ({tx_valid, tx_data, tx_tag, tx_last} !== {1'b1, 4'h0, 2'b10, 1'b1}) begin
            bad++;
            $display("FAIL err_flag: got v=%b d=%h t=%0d l=%b want 1 0 2 1",
                     tx_valid, tx_data, tx_tag, tx_last);
        end
        step();
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL err_flag_idle: got v=%b want 0", tx_valid);
        end
        pulse_done(2'b11, 1'b0, 4'h9, 4'h1);
        total++;
        if ({tx_valid, tx_data, tx_tag, tx_last} !== {1'b1, 4'h0, 2'b10, 1'b1}) begin
            bad++;
            $display("FAIL err_op3: got v=%b d=%h t=%0d l=%b want 1 0 2 1",
                     tx_valid, tx_data, tx_tag, tx_last);
        end
        step();
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL err_op3_idle: got v=%b want 0", tx_valid);
        end
    endtask

    task automatic test_back_to_back();
        tx_ready = 1'b1;
        pulse_done(2'b00, 1'b0, 4'h7, 4'h0);
        total++;
        if ({tx_data, tx_last} !== {4'h7, 1'b1}) begin
            bad++;
            $display("FAIL b2b_first: got d=%h l=%b want 7 1", tx_data, tx_last);
        end
        // Second done coincides with the last MUL handshake.
        pulse_done(2'b10, 1'b0, 4'h5, 4'h1);
        total++;
        if ({tx_valid, tx_data, tx_tag, tx_last, overrun} !== {1'b1, 4'h5, 2'b00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL b2b_second: got v=%b d=%h t=%0d l=%b o=%b want 1 5 0 0 0",
                     tx_valid, tx_data, tx_tag, tx_last, overrun);
        end
        step();
        total++;
        if ({tx_valid, tx_data, tx_tag, tx_last} !== {1'b1, 4'h1, 2'b01, 1'b1}) begin
            bad++;
            $display("FAIL b2b_rem: got v=%b d=%h t=%0d l=%b want 1 1 1 1",
                     tx_valid, tx_data, tx_tag, tx_last);
        end
        step();
        total++;
        if ({tx_valid, overrun} !== 2'b00) begin
            bad++;
            $display("FAIL b2b_idle: got v=%b o=%b want 0 0", tx_valid, overrun);
        end
    endtask

    task automatic test_overrun();
        tx_ready = 1'b0;
        pulse_done(2'b01, 1'b0, 4'h9, 4'h4);
        // Dropped: arrives while SEND_RES is stalled.
        pulse_done(2'b00, 1'b0, 4'hF, 4'hE);
        total++;
        if ({overrun, tx_valid, tx_data, tx_tag, tx_last} !== {1'b1, 1'b1, 4'h9, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL ovr_drop: got o=%b v=%b d=%h t=%0d l=%b want 1 1 9 0 0",
                     overrun, tx_valid, tx_data, tx_tag, tx_last);
        end
        tx_ready = 1'b1;
        step();
        total++;
        if ({tx_data, tx_tag, tx_last} !== {4'h4, 2'b01, 1'b1}) begin
            bad++;
            $display("FAIL ovr_rem: got d=%h t=%0d l=%b want 4 1 1", tx_data, tx_tag, tx_last);
        end
        step();
        step();
        total++;
        if ({tx_valid, overrun} !== 2'b01) begin
            bad++;
            $display("FAIL ovr_sticky: got v=%b o=%b want 0 1", tx_valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b1;
        pulse_done(2'b01, 1'b0, 4'h6, 4'h3);
        step();
        total++;
        if ({tx_valid, tx_data, tx_tag} !== {1'b1, 4'h3, 2'b01}) begin
            bad++;
            $display("FAIL rst_pre: got v=%b d=%h t=%0d want 1 3 1", tx_valid, tx_data, tx_tag);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({tx_valid, overrun, tx_data, tx_tag, tx_last} !== {1'b0, 1'b0, 4'h0, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid: got v=%b o=%b d=%h t=%0d l=%b want 0 0 0 0 0",
                     tx_valid, overrun, tx_data, tx_tag, tx_last);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (tx_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_quiet_%0d: got v=%b want 0", i, tx_valid);
            end
        end
        pulse_done(2'b00, 1'b0, 4'h2, 4'h0);
        total++;
        if ({tx_valid, tx_data, tx_tag, tx_last} !== {1'b1, 4'h2, 2'b00, 1'b1}) begin
            bad++;
            $display("FAIL rst_new: got v=%b d=%h t=%0d l=%b want 1 2 0 1",
                     tx_valid, tx_data, tx_tag, tx_last);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; done = 1'b0; op = 2'b00; error = 1'b0;
        result = '0; remainder = '0; tx_ready = 1'b0;
        test_reset();
        test_mul();
        test_div_stall();
        test_error();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdr_result_sender.md
# mdr_result_sender

Output-side companion to the MDR datapath registers. Captures a finished multiply, divide or square-root result when the core pulses `done`, then hands it to a downstream consumer (display driver or UART framer) as one or two beats over a valid/ready handshake. It adds the flow control and sequencing that the free-running capture registers lack. It sits between the MDR core and any consumer that may stall.

## Interface
- `DW`, 4, operand/result width in bits.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `done`  in  1  single-cycle pulse from MDR core: result, remainder, op and error are valid this cycle.
- `op`  in  2  operation of the finished computation (mdr_pkg op encoding).
- `error`  in  1  core error (divide by zero, negative root operand).
- `result`  in  DW  product, quotient or root.
- `remainder`  in  DW  remainder. Ignored for MUL.
- `tx_ready`  in  1  consumer accepts beat.
- `tx_valid`  out  1  beat available.
- `tx_data`  out  DW  beat payload.
- `tx_tag`  out  2  beat type: RES, REM or ERR.
- `tx_last`  out  1  final beat of this result.
- `busy`  out  1  sender holds an undelivered result.
- `overrun`  out  1  sticky: a `done` was dropped.

## Operation
- States:
  - IDLE: no result held.
  - SEND_RES: presenting the first beat.
  - SEND_REM: presenting the remainder beat.
- Capture condition: `done` is high and either the state is IDLE, or a final-beat handshake (`tx_valid & tx_ready & tx_last`) occurs in the same cycle.
- On capture:
  - Latch `result`, `remainder`, `op` and `error` into the hold registers.
  - Go to SEND_RES.
- Beat content in SEND_RES:
  - If `error` = 1 or `op` = 2'b11: `tx_data` = 0, `tx_tag` = ERR, `tx_last` = 1.
  - Else if `op` = MUL: `tx_data` = result, `tx_tag` = RES, `tx_last` = 1.
  - Else (DIV, SQRT): `tx_data` = result, `tx_tag` = RES, `tx_last` = 0.
- SEND_REM: `tx_data` = held remainder, `tx_tag` = REM, `tx_last` = 1.
- Transitions on handshake:
  - Non-last beat accepted: SEND_RES -> SEND_REM.
  - Last beat accepted, no capture in the same cycle: -> IDLE.
  - Last beat accepted with a capture in the same cycle: -> SEND_RES with the new data. This gives zero-bubble back-to-back results.
- `done` outside the capture condition is dropped:
  - `overrun` is set and stays set until `rst`.
  - Hold registers are unchanged.
- `tx_valid` = (state != IDLE). `busy` is identical to `tx_valid`.
- While `tx_valid` = 1 and `tx_ready` = 0, `tx_data`, `tx_tag` and `tx_last` hold stable.
- `tx_ready` in IDLE is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `tx_valid`, `tx_last`, `busy` and `overrun` = 0.
  - `tx_data` = 0, `tx_tag` = RES (2'b00).
  - Hold registers = 0.
- Reset mid-transfer abandons the held result. No beat appears after reset until a new `done` arrives.
- Latency: `done` at edge N -> `tx_valid` = 1 after edge N+1 (registered, one cycle).
- A beat transfers on a rising edge where `tx_valid` & `tx_ready` = 1. The next beat, or the deasserted valid, appears after that edge.
- Throughput with `tx_ready` held high:
  - MUL: one beat per cycle.
  - DIV/SQRT: two cycles per result.
- All outputs are registered or decoded from state and hold registers only. There is no combinational path from `tx_ready` or `done` to any output.

## Structure
- `mdr_pkg` (shared):
  - `op_t`: MUL=2'b00, DIV=2'b01, SQRT=2'b10.
  - `tag_t`: RES=2'b00, REM=2'b01, ERR=2'b10.
  - `sender_state_t`.
- Sub-module `mdr_hold_reg #(DW)`:
  - Enabled register with synchronous active-high reset to 0.
  - Instantiated once per held field: result, remainder, op, error.
- FSM and output decode live in `mdr_result_sender`.

## Test plan
All scenarios use DW = 4.
- MUL: `done` with op=MUL, result=4'hC, `tx_ready`=1 -> one beat next cycle: data=C, tag=RES, last=1. Then `busy`=0.
- DIV stall: op=DIV, result=3, remainder=2, `tx_ready`=0 for 3 cycles -> data=3/RES/last=0 held stable for 3 cycles. Raise ready -> data=2/REM/last=1, then IDLE.
- Error: op=DIV, error=1 -> single beat data=0, tag=ERR, last=1. op=2'b11 with error=0 -> same beat.
- Back-to-back: second `done` (op=SQRT, result=5, remainder=1) in the same cycle as the last MUL handshake -> next cycle data=5/RES with no idle gap. `overrun` stays 0.
- Overrun: `done` while in SEND_RES with `tx_ready`=0 -> `overrun`=1, held beat unchanged. `overrun` stays 1 until `rst`.
- Reset mid-operation: assert `rst` in SEND_REM -> next cycle `tx_valid`=0, `overrun`=0, `tx_data`=0. No beat appears until a new `done`.
